mips32r1_wb_arb2: RTL and testbench
===================================

// Module: mips32r1_wb_arb2
// PURPOSE
//  Two-master, one-slave Wishbone B3 classic arbiter sharing one slave port (e.g. a single boot ROM or SRAM).
//  Masters are the CPU instruction bridge (m0) and the data bridge (m1).
//  Grant is round-robin and locked for the whole cyc; slave-side signals are muxed from the granted master.
//  Sits between the two bus bridges and the interconnect slave port.
// PARAMETERS
//  AW              32   address width
//  DW              32   data width; SEL width = DW/8
//  TIMEOUT_CYCLES  255  wait-state limit before forced err (WB_ARB_TIMEOUT_EN only); legal 1..65535
// PORTS
//  wb_clk_i   in   1      bus clock; all state changes on posedge
//  wb_rst_i   in   1      synchronous, active-high reset
//  mN_adr_i   in   AW     master N address (N=0,1; likewise below)
//  mN_dat_i   in   DW     master N write data
//  mN_we_i    in   1      master N write enable
//  mN_sel_i   in   DW/8   master N byte selects
//  mN_stb_i   in   1      master N strobe
//  mN_cyc_i   in   1      master N cycle
//  mN_dat_o   out  DW     read data to master N (= s_dat_i, unqualified)
//  mN_ack_o   out  1      ack to master N (only while granted)
//  mN_err_o   out  1      err to master N (only while granted)
//  s_adr_o    out  AW     slave address
//  s_dat_o    out  DW     slave write data
//  s_we_o     out  1      slave write enable
//  s_sel_o    out  DW/8   slave byte selects
//  s_stb_o    out  1      slave strobe
//  s_cyc_o    out  1      slave cycle
//  s_dat_i    in   DW     slave read data
//  s_ack_i    in   1      slave ack
//  s_err_i    in   1      slave err (tie 0 if absent)
// BEHAVIOUR
//  - FSM states: IDLE, GNT0, GNT1, DRAIN (DRAIN exists only with WB_ARB_TIMEOUT_EN). Register `last` records the most recently granted master.
//  - Reset: state=IDLE, last=1 (m0 wins the first tie). Timeout counter = 0.
//  - Outputs in reset and IDLE: s_cyc_o=s_stb_o=s_we_o=0; s_adr_o/s_dat_o/s_sel_o = 0; all mN_ack_o/mN_err_o = 0.
//  - Arbitration (IDLE): only m0_cyc_i -> GNT0; only m1_cyc_i -> GNT1; both -> grant !last; neither -> stay in IDLE.
//    The grant takes effect on the next edge, so arbitration latency is 1 cycle.
//  - GNTn: s_* = mN_* combinationally, with s_cyc_o/s_stb_o gated by grant. mN_ack_o = s_ack_i, mN_err_o = s_err_i.
//    The other master sees ack=err=0 and waits; its request stays pending.
//  - Grant is held while mN_cyc_i=1, including stb=0 gaps (lock). On mN_cyc_i=0: -> IDLE and last<=N.
//    A pending request from the other master is granted on the following edge, giving a 1 idle cycle between owners.
//  - Back-to-back: if both masters request continuously, grants alternate m0,m1,m0,... Neither master waits for more than one foreign cycle.
//  - Reset asserted mid-transfer: next edge -> IDLE, s_cyc_o drops immediately. The slave must tolerate an abandoned cycle.
//  - Acks arriving in IDLE are discarded and are not forwarded.
// CONFIGURATION
//  WB_ARB_TIMEOUT_EN defined:
//   - A counter increments each GNTn cycle with s_stb_o=1 and s_ack_i=s_err_i=0; it clears on ack/err and on grant change.
//   - On reaching TIMEOUT_CYCLES: mN_err_o=1 for exactly 1 cycle, s_cyc_o/s_stb_o forced 0, state -> DRAIN.
//   - DRAIN: the slave is not driven; stay until the owner drops cyc, then -> IDLE, last<=N.
//  WB_ARB_TIMEOUT_EN undefined: no counter, no DRAIN; a stalled slave holds the grant indefinitely.
// STRUCTURE
//  - Package mips32r1_wb_arb_pkg: state encoding localparams (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2, DRAIN=2'd3), master index constants M_IBUS=0, M_DBUS=1.
//  - Sub-module mips32r1_wb_arb_wdog (timeout counter: clear, count_en, expired). Instantiated only under WB_ARB_TIMEOUT_EN.
//  - The rest is one registered FSM plus combinational muxes.
// TESTING
//  1. m0 alone reads 0x00000010, slave acks after 2 waits -> s_cyc_o high the cycle after m0_cyc_i; m0_ack_o pulses once; m1_ack_o stays 0.
//  2. m0, m1 raise cyc in the same cycle after reset -> m0 granted first; on m0 cyc drop, 1 idle cycle, then m1 granted.
//  3. Both masters request continuously for 6 cycles each -> grants alternate 0,1,0,1; no ack ever reaches the non-owner.
//  4. m1 holds cyc with stb low for 3 cycles between two writes (sel=4'b0011, dat=0xA5A5_0000) -> grant stays m1; m0 is blocked until m1 cyc=0.
//  5. wb_rst_i asserted during a granted read -> next cycle s_cyc_o=0, all acks/errs 0, state IDLE; the next tie is granted to m0.
//  6. WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> m0_err_o pulses 1 cycle after 8 waits; s_cyc_o=0; m1 is granted only after m0 drops cyc.

Source files
------------

// File: rtl/mips32r1_wb_arb_pkg.sv
// Shared encodings for the two-master Wishbone arbiter: FSM states and master indices.
package mips32r1_wb_arb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT0  = 2'd1;
  localparam logic [1:0] GNT1  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_GNT0  = GNT0,
    ST_GNT1  = GNT1,
    ST_DRAIN = DRAIN
  } arb_state_e;

  localparam logic M_IBUS = 1'b0;
  localparam logic M_DBUS = 1'b1;

endpackage

// File: rtl/mips32r1_wb_arb_wdog.sv
// Wait-state watchdog for the arbiter: counts stalled strobe cycles and flags
// expiry once TIMEOUT_CYCLES is reached; holds there until cleared.
module mips32r1_wb_arb_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] count_r;

  // Stall counter; saturates at LIMIT so expiry stays visible until cleared.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      count_r <= 16'd0;
    end else if (clear) begin
      count_r <= 16'd0;
    end else if (count_en && (count_r != LIMIT)) begin
      count_r <= count_r + 16'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LIMIT);

endmodule

// File: rtl/mips32r1_wb_arb2.sv
// Two-master (ibus=m0, dbus=m1) round-robin Wishbone B3 classic arbiter onto one slave.
// Define WB_ARB_TIMEOUT_EN to add the wait-state watchdog and DRAIN state.
module mips32r1_wb_arb2
  import mips32r1_wb_arb_pkg::*;
#(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_stb_i,
  input  logic            m0_cyc_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_stb_i,
  input  logic            m1_cyc_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_stb_o,
  output logic            s_cyc_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("mips32r1_wb_arb2: TIMEOUT_CYCLES out of range 1..65535");
  end

  arb_state_e state_r;
  logic       last_r;
  logic       gnt0_s;
  logic       gnt1_s;
  logic       expired_s;

  assign gnt0_s = (state_r == ST_GNT0) && !wb_rst_i;
  assign gnt1_s = (state_r == ST_GNT1) && !wb_rst_i;

`ifdef WB_ARB_TIMEOUT_EN
  logic drain_owner_r;
  logic wdog_clear_s;
  logic wdog_count_en_s;

  assign wdog_clear_s    = !(gnt0_s || gnt1_s) || s_ack_i || s_err_i;
  assign wdog_count_en_s = s_stb_o && !s_ack_i && !s_err_i;

  mips32r1_wb_arb_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .clear    (wdog_clear_s),
    .count_en (wdog_count_en_s),
    .expired  (expired_s)
  );
`else
  assign expired_s = 1'b0;
`endif

  // Arbitration FSM: grant is locked for the owner's whole cyc, ties go to !last.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r <= ST_IDLE;
      last_r  <= M_DBUS;
`ifdef WB_ARB_TIMEOUT_EN
      drain_owner_r <= M_IBUS;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (m0_cyc_i && m1_cyc_i) begin
            state_r <= (last_r == M_DBUS) ? ST_GNT0 : ST_GNT1;
          end else if (m0_cyc_i) begin
            state_r <= ST_GNT0;
          end else if (m1_cyc_i) begin
            state_r <= ST_GNT1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GNT0: begin
          if (!m0_cyc_i) begin
            state_r <= ST_IDLE;
            last_r  <= M_IBUS;
`ifdef WB_ARB_TIMEOUT_EN
          end else if (expired_s) begin
            state_r       <= ST_DRAIN;
            drain_owner_r <= M_IBUS;
`endif
          end else begin
            state_r <= ST_GNT0;
          end
        end
        ST_GNT1: begin
          if (!m1_cyc_i) begin
            state_r <= ST_IDLE;
            last_r  <= M_DBUS;
`ifdef WB_ARB_TIMEOUT_EN
          end else if (expired_s) begin
            state_r       <= ST_DRAIN;
            drain_owner_r <= M_DBUS;
`endif
          end else begin
            state_r <= ST_GNT1;
          end
        end
`ifdef WB_ARB_TIMEOUT_EN
        ST_DRAIN: begin
          if (((drain_owner_r == M_IBUS) && !m0_cyc_i) ||
              ((drain_owner_r == M_DBUS) && !m1_cyc_i)) begin
            state_r <= ST_IDLE;
            last_r  <= drain_owner_r;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
`endif
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Slave-side mux from the granted master; everything quiet in IDLE, DRAIN and reset.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_stb_o = 1'b0;
    s_cyc_o = 1'b0;
    if (gnt0_s) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
      s_cyc_o = m0_cyc_i && !expired_s;
      s_stb_o = m0_cyc_i && m0_stb_i && !expired_s;
    end else if (gnt1_s) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;
      s_cyc_o = m1_cyc_i && !expired_s;
      s_stb_o = m1_cyc_i && m1_stb_i && !expired_s;
    end else begin
      s_cyc_o = 1'b0;
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = gnt0_s && !expired_s && s_ack_i;
  assign m1_ack_o = gnt1_s && !expired_s && s_ack_i;
  assign m0_err_o = gnt0_s && (s_err_i || expired_s);
  assign m1_err_o = gnt1_s && (s_err_i || expired_s);

endmodule

// File: tb/tb_mips32r1_wb_arb2.sv
// Directed self-checking bench for mips32r1_wb_arb2 (timeout scenario only with WB_ARB_TIMEOUT_EN).
`timescale 1ns/1ps
module tb_mips32r1_wb_arb2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_adr, m0_dat_w, m0_dat_r, m1_adr, m1_dat_w, m1_dat_r;
  logic        m0_we, m0_stb, m0_cyc, m0_ack, m0_err;
  logic        m1_we, m1_stb, m1_cyc, m1_ack, m1_err;
  logic [3:0]  m0_sel, m1_sel, s_sel;
  logic [31:0] s_adr, s_dat_w, s_dat_r;
  logic        s_we, s_stb, s_cyc, s_ack, s_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mips32r1_wb_arb2 #(.AW(32), .DW(32), .TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat_w), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_dat_o(m0_dat_r), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat_w), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_dat_o(m1_dat_r), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_adr_o(s_adr), .s_dat_o(s_dat_w), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_dat_i(s_dat_r), .s_ack_i(s_ack), .s_err_i(s_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m0_adr = 32'h0; m0_dat_w = 32'h0; m0_we = 1'b0; m0_sel = 4'h0; m0_stb = 1'b0; m0_cyc = 1'b0;
    m1_adr = 32'h0; m1_dat_w = 32'h0; m1_we = 1'b0; m1_sel = 4'h0; m1_stb = 1'b0; m1_cyc = 1'b0;
    s_dat_r = 32'h0; s_ack = 1'b0; s_err = 1'b0;
    tick(); tick();
    settle();
    check("rst_cyc", {31'd0, s_cyc}, 32'd0);
    check("rst_adr", s_adr, 32'd0);
    check("rst_ack", {30'd0, m0_ack, m1_ack}, 32'd0);
    rst = 1'b0;

    // 1: m0 alone reads 0x10, slave acks after two wait states
    m0_adr = 32'h0000_0010; m0_sel = 4'hF; m0_we = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
    settle();
    check("t1_arb_lat", {31'd0, s_cyc}, 32'd0);
    tick();
    check("t1_cyc", {31'd0, s_cyc}, 32'd1);
    check("t1_adr", s_adr, 32'h0000_0010);
    check("t1_wait1", {31'd0, m0_ack}, 32'd0);
    tick();
    check("t1_wait2", {31'd0, m0_ack}, 32'd0);
    tick();
    s_ack = 1'b1; s_dat_r = 32'hDEAD_BEEF;
    settle();
    check("t1_ack0", {31'd0, m0_ack}, 32'd1);
    check("t1_ack1", {31'd0, m1_ack}, 32'd0);
    check("t1_dat", m0_dat_r, 32'hDEAD_BEEF);
    tick();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    settle();
    check("t1_drop", {31'd0, s_cyc}, 32'd0);
    check("t1_noack", {31'd0, m0_ack}, 32'd0);
    tick();

    // 2: simultaneous request right after reset, m0 wins, one idle cycle, then m1
    rst = 1'b1; tick(); rst = 1'b0;
    m0_adr = 32'h0000_0100; m1_adr = 32'h0000_0200;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    s_ack = 1'b1;
    settle();
    check("t2_first", s_adr, 32'h0000_0100);
    check("t2_ack0", {31'd0, m0_ack}, 32'd1);
    check("t2_ack1", {31'd0, m1_ack}, 32'd0);
    tick();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    check("t2_idle", {31'd0, s_cyc}, 32'd0);
    tick();
    check("t2_second", s_adr, 32'h0000_0200);
    check("t2_cyc", {31'd0, s_cyc}, 32'd1);
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();

    // 3: continuous requests from both, grants must alternate 0,1,0,1
    m0_adr = 32'h0000_1000; m1_adr = 32'h0000_2000;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 6; k++) begin
        s_ack = 1'b1;
        settle();
        check("t3_owner", s_adr, (g % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
        check("t3_ack0", {31'd0, m0_ack}, (g % 2 == 0) ? 32'd1 : 32'd0);
        check("t3_ack1", {31'd0, m1_ack}, (g % 2 == 0) ? 32'd0 : 32'd1);
        tick();
      end
      s_ack = 1'b0;
      if (g % 2 == 0) m0_cyc = 1'b0; else m1_cyc = 1'b0;
      tick();
      if (g % 2 == 0) m0_cyc = 1'b1; else m1_cyc = 1'b1;
      s_ack = 1'b1;
      settle();
      check("t3_gap", {31'd0, s_cyc}, 32'd0);
      check("t3_idle_ack", {30'd0, m0_ack, m1_ack}, 32'd0);
      s_ack = 1'b0;
      tick();
    end
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();

    // 4: m1 locks the bus across a three-cycle stb gap between two writes
    m1_adr = 32'h0000_0300; m1_we = 1'b1; m1_sel = 4'b0011; m1_dat_w = 32'hA5A5_0000;
    m1_cyc = 1'b1; m1_stb = 1'b1;
    m0_adr = 32'h0000_0400; m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    s_ack = 1'b1;
    settle();
    check("t4_we", {31'd0, s_we}, 32'd1);
    check("t4_sel", {28'd0, s_sel}, 32'h3);
    check("t4_dat", s_dat_w, 32'hA5A5_0000);
    check("t4_ack1", {31'd0, m1_ack}, 32'd1);
    check("t4_ack0", {31'd0, m0_ack}, 32'd0);
    tick();
    s_ack = 1'b0; m1_stb = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("t4_gap_stb", {31'd0, s_stb}, 32'd0);
      check("t4_gap_cyc", {31'd0, s_cyc}, 32'd1);
      check("t4_gap_own", s_adr, 32'h0000_0300);
      tick();
    end
    m1_stb = 1'b1; s_ack = 1'b1;
    settle();
    check("t4_ack1b", {31'd0, m1_ack}, 32'd1);
    tick();
    s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    tick();
    check("t4_idle", {31'd0, s_cyc}, 32'd0);
    tick();
    check("t4_m0_gnt", s_adr, 32'h0000_0400);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    tick();

    // 5: reset during m1's read, then a tie must go to m0
    m1_adr = 32'h0000_0500; m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    check("t5_gnt1", s_adr, 32'h0000_0500);
    rst = 1'b1;
    tick();
    s_ack = 1'b1;
    settle();
    check("t5_rst_cyc", {31'd0, s_cyc}, 32'd0);
    check("t5_rst_ack", {30'd0, m0_ack, m1_ack}, 32'd0);
    check("t5_rst_err", {30'd0, m0_err, m1_err}, 32'd0);
    rst = 1'b0;
    m0_adr = 32'h0000_0600; m0_cyc = 1'b1; m0_stb = 1'b1;
    settle();
    check("t5_idle_ack", {30'd0, m0_ack, m1_ack}, 32'd0);
    s_ack = 1'b0;
    tick();
    check("t5_tie_m0", s_adr, 32'h0000_0600);
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    tick();

`ifdef WB_ARB_TIMEOUT_EN
    // 6: slave never answers; m0 gets one err after 8 waits, m1 waits for m0's drop
    rst = 1'b1; tick(); rst = 1'b0;
    m0_adr = 32'h0000_0700; m0_cyc = 1'b1; m0_stb = 1'b1;
    m1_adr = 32'h0000_0800; m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      check("t6_wait_err", {31'd0, m0_err}, 32'd0);
      check("t6_wait_cyc", {31'd0, s_cyc}, 32'd1);
      tick();
    end
    check("t6_err", {31'd0, m0_err}, 32'd1);
    check("t6_cyc_off", {31'd0, s_cyc}, 32'd0);
    check("t6_err1", {31'd0, m1_err}, 32'd0);
    tick();
    check("t6_err_pulse", {31'd0, m0_err}, 32'd0);
    check("t6_drain_cyc", {31'd0, s_cyc}, 32'd0);
    tick();
    check("t6_drain_hold", {31'd0, s_cyc}, 32'd0);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    tick();
    check("t6_m1_gnt", s_adr, 32'h0000_0800);
    check("t6_m1_cyc", {31'd0, s_cyc}, 32'd1);
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
